frog_position_ctrl: RTL and testbench
=====================================

// Module: frog_position_ctrl
// PURPOSE
//   Converts the four debounced switch levels into the frog's tile-snapped pixel position.
//   Sits between the Debounce_Switch instances (upstream) and Sprite_Display (downstream).
//   Replaces the fixed X/Y position registers in the game top.
//   Enforces playfield bounds and a post-hop cooldown; flags goal reach and blocked moves.
// PARAMETERS
//   TILE_SIZE     16        pixels per tile; must be a power of two
//   GRID_COLS     20        playfield width, in tiles
//   GRID_ROWS     15        playfield height, in tiles
//   START_COL     10        spawn column
//   START_ROW     12        spawn row
//   COOLDOWN_CYC  2_500_000 cycles during which input is ignored after a hop (100 ms at 25 MHz)
//   REPEAT_CYC    5_000_000 auto-repeat period while a switch is held (used only with HOP_REPEAT_EN)
//   POS_W         9         position output width; (GRID_COLS-1)*TILE_SIZE must be < 2**POS_W
// PORTS
//   i_Clk         in   1      system clock (VGA pixel clock domain)
//   i_Reset       in   1      synchronous, active-high reset
//   i_Switch_Up   in   1      debounced Switch_1 level
//   i_Switch_Down in   1      debounced Switch_2 level
//   i_Switch_Left in   1      debounced Switch_3 level
//   i_Switch_Right in  1      debounced Switch_4 level
//   i_Respawn     in   1      one-cycle pulse from game logic (death or goal): return to spawn
//   o_X_Position  out  POS_W  frog pixel X, equal to col*TILE_SIZE
//   o_Y_Position  out  POS_W  frog pixel Y, equal to row*TILE_SIZE
//   o_Hop_Pulse   out  1      1-cycle pulse on each successful move
//   o_Blocked     out  1      1-cycle pulse when a move is refused at an edge
//   o_At_Goal     out  1      level; high while row == 0
// BEHAVIOUR
//   Reset values:
//     - col = START_COL, row = START_ROW, so X = START_COL*TILE_SIZE and Y = START_ROW*TILE_SIZE.
//     - o_Hop_Pulse = 0, o_Blocked = 0, o_At_Goal = (START_ROW == 0).
//     - State = IDLE; previous-switch registers = 0.
//   Edge detection:
//     - A request is a switch level of 1 while its registered previous value is 0.
//     - On the cycle it is detected (cycle t), outputs update at the t+1 edge. Latency is 1 clock.
//   States:
//     - IDLE: on a request, attempt the move.
//         - Target in bounds: update col/row, pulse o_Hop_Pulse, go to COOLDOWN.
//         - Target out of bounds: pulse o_Blocked, position unchanged, stay in IDLE.
//     - COOLDOWN: counter runs 0 to COOLDOWN_CYC-1, then returns to IDLE.
//         - Requests arriving here are dropped, not queued.
//         - The previous-switch registers keep tracking, so an edge during cooldown is lost.
//   Simultaneous requests: fixed priority Up > Down > Left > Right; exactly one move per hop.
//   Bounds (no wrap-around):
//     - Up refused at row 0; Down refused at row GRID_ROWS-1.
//     - Left refused at col 0; Right refused at col GRID_COLS-1.
//   Arithmetic:
//     - col/row are held as tile indices of width $clog2(GRID_*).
//     - Position = index << log2(TILE_SIZE), zero-extended to POS_W; no multiplier.
//   i_Respawn:
//     - In any state: next edge loads the spawn tile, state goes to COOLDOWN, counter clears.
//     - No o_Hop_Pulse is generated.
//     - Respawn has priority over a same-cycle switch request.
//   i_Reset: overrides everything; mid-hop or mid-cooldown it returns to the reset values above.
// CONFIGURATION
//   HOP_REPEAT_EN defined:
//     - If the switch that caused the hop is still held at the end of COOLDOWN, a repeat counter runs.
//     - Every REPEAT_CYC cycles it issues another move in the same direction (bounds still apply).
//     - Releasing that switch, or pressing any other switch, cancels the repeat.
//   HOP_REPEAT_EN undefined:
//     - A held switch produces exactly one hop; the player must release and press again.
//     - The repeat counter is not synthesised.
// STRUCTURE
//   Constants.v holds the shared definitions:
//     - TILE_SIZE, GRID_COLS, GRID_ROWS, START_COL, START_ROW.
//     - Direction encoding DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
//     - State encoding ST_IDLE, ST_COOLDOWN.
//   Sub-module switch_edge_detect, instanced 4 times: one registered level, outputs a rising-edge pulse.
// TESTING
//   - Reset, then idle 10 cycles -> X=160, Y=192, o_At_Goal=0, no pulses.
//   - Up edge (COOLDOWN_CYC=8 in bench) -> next cycle Y=176, o_Hop_Pulse=1 for 1 cycle; second Up edge 3 cycles later is ignored.
//   - 12 Up hops, each spaced beyond cooldown -> Y=0, o_At_Goal=1; 13th Up -> o_Blocked pulse, Y stays 0.
//   - Up and Right edges in the same cycle -> only Y decrements; X stays 160.
//   - Start at col 19 and press Right -> o_Blocked, X=304; i_Respawn with Left edge same cycle -> X=160, Y=192, no o_Hop_Pulse.
//   - HOP_REPEAT_EN with REPEAT_CYC=16, hold Left 60 cycles -> hops at t+1, then every 16 cycles after cooldown; release -> stops.

Source files
------------

// File: rtl/frog_position_ctrl_pkg.sv
// Shared constants and encodings for the frog position controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package frog_position_ctrl_pkg;

    localparam int DEF_TILE_SIZE    = 16;
    localparam int DEF_GRID_COLS    = 20;
    localparam int DEF_GRID_ROWS    = 15;
    localparam int DEF_START_COL    = 10;
    localparam int DEF_START_ROW    = 12;
    localparam int DEF_COOLDOWN_CYC = 2_500_000;
    localparam int DEF_REPEAT_CYC   = 5_000_000;
    localparam int DEF_POS_W        = 9;

    // Values double as bit indices into the packed switch vector.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_COOLDOWN = 1'b1
    } state_t;

endpackage

// File: rtl/frog_position_ctrl_edge_detect.sv
// Rising-edge detector for one debounced switch level.
// Latency: combinational pulse in the cycle the level first reads 1.
// Backpressure: none; the previous level is tracked unconditionally.
// Ports: i_Clk, i_Reset (sync, active-high), i_Level in, o_Rise out.
module switch_edge_detect (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Level,
    output logic o_Rise
);

    logic level_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= i_Level;
        end
    end

    assign o_Rise = i_Level & ~level_q;

endmodule

// File: rtl/frog_position_ctrl.sv
// Turns switch presses into a tile-snapped, bounded frog position with post-hop cooldown.
// Latency: 1 clock from a detected switch edge (or respawn) to updated position/pulses.
// Backpressure: none; presses during cooldown are dropped. Optional macro HOP_REPEAT_EN adds auto-repeat.
// Ports: i_Clk, i_Reset (sync, active-high), i_Switch_Up/Down/Left/Right levels, i_Respawn pulse;
//        o_X_Position/o_Y_Position pixels, o_Hop_Pulse, o_Blocked pulses, o_At_Goal level.
module frog_position_ctrl
    import frog_position_ctrl_pkg::*;
#(
    parameter int TILE_SIZE    = DEF_TILE_SIZE,
    parameter int GRID_COLS    = DEF_GRID_COLS,
    parameter int GRID_ROWS    = DEF_GRID_ROWS,
    parameter int START_COL    = DEF_START_COL,
    parameter int START_ROW    = DEF_START_ROW,
    parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC,
`ifdef HOP_REPEAT_EN
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
`endif
    parameter int POS_W        = DEF_POS_W
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Switch_Up,
    input  logic             i_Switch_Down,
    input  logic             i_Switch_Left,
    input  logic             i_Switch_Right,
    input  logic             i_Respawn,
    output logic [POS_W-1:0] o_X_Position,
    output logic [POS_W-1:0] o_Y_Position,
    output logic             o_Hop_Pulse,
    output logic             o_Blocked,
    output logic             o_At_Goal
);

    localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int SHIFT = $clog2(TILE_SIZE);
    localparam int CNT_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(GRID_ROWS - 1);
    localparam logic [COL_W-1:0] COL_SPAWN = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] ROW_SPAWN = ROW_W'(START_ROW);
    localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(COOLDOWN_CYC - 1);

    logic [3:0] sw_lvl;
    logic [3:0] sw_rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             hop_q, hop_d;
    logic             blk_q, blk_d;
    logic             try_vld;
    dir_t             try_dir;

`ifdef HOP_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);

    // rpt_arm: the last successful hop direction is known; rpt_on: repeat counter running.
    dir_t             rpt_dir_q, rpt_dir_d;
    logic             rpt_arm_q, rpt_arm_d;
    logic             rpt_on_q, rpt_on_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    // Bit index of each switch matches its dir_t encoding.
    assign sw_lvl = {i_Switch_Right, i_Switch_Left, i_Switch_Down, i_Switch_Up};

    for (genvar g = 0; g < 4; g++) begin : g_edge
        switch_edge_detect u_edge (
            .i_Clk   (i_Clk),
            .i_Reset (i_Reset),
            .i_Level (sw_lvl[g]),
            .o_Rise  (sw_rise[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        hop_d   = 1'b0;
        blk_d   = 1'b0;
        try_vld = 1'b0;
        try_dir = DIR_UP;
`ifdef HOP_REPEAT_EN
        rpt_dir_d = rpt_dir_q;
        rpt_arm_d = rpt_arm_q;
        rpt_on_d  = rpt_on_q;
        rpt_cnt_d = rpt_cnt_q;
`endif

        if (i_Respawn) begin
            // Respawn wins over any same-cycle press and never pulses a hop.
            col_d   = COL_SPAWN;
            row_d   = ROW_SPAWN;
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
`ifdef HOP_REPEAT_EN
            rpt_arm_d = 1'b0;
            rpt_on_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_COOLDOWN: begin
                    if (cnt_q == CD_LAST) begin
                        state_d = ST_IDLE;
`ifdef HOP_REPEAT_EN
                        rpt_on_d  = rpt_arm_q & sw_lvl[rpt_dir_q];
                        rpt_cnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (|sw_rise) begin
                        try_vld = 1'b1;
                        if (sw_rise[DIR_UP])        try_dir = DIR_UP;
                        else if (sw_rise[DIR_DOWN]) try_dir = DIR_DOWN;
                        else if (sw_rise[DIR_LEFT]) try_dir = DIR_LEFT;
                        else                        try_dir = DIR_RIGHT;
`ifdef HOP_REPEAT_EN
                        rpt_on_d = 1'b0;
                    end else if (rpt_on_q) begin
                        if (!sw_lvl[rpt_dir_q]) begin
                            rpt_on_d = 1'b0;
                        end else if (rpt_cnt_q == RPT_LAST) begin
                            try_vld   = 1'b1;
                            try_dir   = rpt_dir_q;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + 1'b1;
                        end
`endif
                    end
                end
            endcase
        end

        if (try_vld) begin
            case (try_dir)
                DIR_UP:   if (row_q == '0)     blk_d = 1'b1; else begin row_d = row_q - 1'b1; hop_d = 1'b1; end
                DIR_DOWN: if (row_q == ROW_MAX) blk_d = 1'b1; else begin row_d = row_q + 1'b1; hop_d = 1'b1; end
                DIR_LEFT: if (col_q == '0)     blk_d = 1'b1; else begin col_d = col_q - 1'b1; hop_d = 1'b1; end
                default:  if (col_q == COL_MAX) blk_d = 1'b1; else begin col_d = col_q + 1'b1; hop_d = 1'b1; end
            endcase
            if (hop_d) begin
                state_d = ST_COOLDOWN;
                cnt_d   = '0;
`ifdef HOP_REPEAT_EN
                rpt_arm_d = 1'b1;
                rpt_dir_d = try_dir;
                rpt_on_d  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            col_q   <= COL_SPAWN;
            row_q   <= ROW_SPAWN;
            hop_q   <= 1'b0;
            blk_q   <= 1'b0;
`ifdef HOP_REPEAT_EN
            rpt_dir_q <= DIR_UP;
            rpt_arm_q <= 1'b0;
            rpt_on_q  <= 1'b0;
            rpt_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hop_q   <= hop_d;
            blk_q   <= blk_d;
`ifdef HOP_REPEAT_EN
            rpt_dir_q <= rpt_dir_d;
            rpt_arm_q <= rpt_arm_d;
            rpt_on_q  <= rpt_on_d;
            rpt_cnt_q <= rpt_cnt_d;
`endif
        end
    end

    // Power-of-two tile size: pixel position is a plain shift of the tile index.
    assign o_X_Position = POS_W'(col_q) << SHIFT;
    assign o_Y_Position = POS_W'(row_q) << SHIFT;
    assign o_Hop_Pulse  = hop_q;
    assign o_Blocked    = blk_q;
    assign o_At_Goal    = (row_q == '0);

endmodule

// File: tb/tb_frog_position_ctrl.sv
module tb_frog_position_ctrl;

    localparam int C = 8;
    localparam int R = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, respawn = 1'b0;
    logic [8:0] x_pos, y_pos;
    logic       hop, blk, goal;

    int checks   = 0;
    int failures = 0;

    frog_position_ctrl #(
        .COOLDOWN_CYC (C),
`ifdef HOP_REPEAT_EN
        .REPEAT_CYC   (R),
`endif
        .POS_W        (9)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Switch_Up    (up),
        .i_Switch_Down  (dn),
        .i_Switch_Left  (lf),
        .i_Switch_Right (rt),
        .i_Respawn      (respawn),
        .o_X_Position   (x_pos),
        .o_Y_Position   (y_pos),
        .o_Hop_Pulse    (hop),
        .o_Blocked      (blk),
        .o_At_Goal      (goal)
    );

    always #5 clk = ~clk;

    // Behavioural model: tile indices, a cooldown countdown, and previous switch levels.
    int       m_col = 10, m_row = 12, m_cd = 0;
    bit       m_hop = 0, m_blk = 0, m_ok = 0;
    bit [3:0] m_prev = 0;
    int       m_rdir = -1, m_rcnt = 0;
    bit       m_ron = 0;

    always @(posedge clk) begin
        bit [3:0] s;
        bit [3:0] req;
        int d, tc, tr;
        s   = {rt, lf, dn, up};
        req = s & ~m_prev;
        m_prev = s;
        d = -1;
        if (rst) begin
            m_col = 10; m_row = 12; m_cd = 0; m_hop = 0; m_blk = 0;
            m_prev = 0; m_rdir = -1; m_ron = 0; m_rcnt = 0; m_ok = 1;
        end else begin
            m_hop = 0; m_blk = 0;
            if (respawn) begin
                m_col = 10; m_row = 12; m_cd = C; m_rdir = -1; m_ron = 0;
            end else if (m_cd > 0) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) begin
                    m_ron  = (m_rdir >= 0) && s[m_rdir];
                    m_rcnt = 0;
                end
            end else if (req != 0) begin
                for (int k = 3; k >= 0; k--) if (req[k]) d = k;
                m_ron = 0;
            end else if (m_ron) begin
`ifdef HOP_REPEAT_EN
                if (!s[m_rdir]) m_ron = 0;
                else if (m_rcnt == R - 1) begin d = m_rdir; m_rcnt = 0; end
                else m_rcnt = m_rcnt + 1;
`else
                m_ron = 0;
`endif
            end
            if (d >= 0) begin
                tc = m_col + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
                tr = m_row + ((d == 1) ? 1 : (d == 0) ? -1 : 0);
                if (tc < 0 || tc > 19 || tr < 0 || tr > 14) begin
                    m_blk = 1;
                end else begin
                    m_col = tc; m_row = tr; m_hop = 1; m_cd = C; m_rdir = d; m_ron = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            checks++;
            if (int'(x_pos) != m_col * 16 || int'(y_pos) != m_row * 16 ||
                hop != m_hop || blk != m_blk || goal != (m_row == 0)) begin
                failures++;
                $display("FAIL model t=%0t got x=%0d y=%0d hop=%0b blk=%0b goal=%0b want x=%0d y=%0d hop=%0b blk=%0b goal=%0b",
                         $time, x_pos, y_pos, hop, blk, goal,
                         m_col * 16, m_row * 16, m_hop, m_blk, (m_row == 0));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        case (d)
            0: up = 1'b1;
            1: dn = 1'b1;
            2: lf = 1'b1;
            default: rt = 1'b1;
        endcase
        tick(1);
        up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        chk("reset_x", x_pos, 160);
        chk("reset_y", y_pos, 192);
        chk("reset_goal", goal, 0);
        chk("reset_hop", hop, 0);
        chk("reset_blk", blk, 0);

        press(0);
        chk("up1_y", y_pos, 176);
        chk("up1_hop", hop, 1);
        tick(1);
        chk("up1_hop_end", hop, 0);
        tick(1);
        press(0);
        chk("up_in_cooldown_y", y_pos, 176);
        chk("up_in_cooldown_hop", hop, 0);
        tick(12);

        for (int i = 0; i < 11; i++) begin
            press(0);
            tick(10);
        end
        chk("top_y", y_pos, 0);
        chk("top_goal", goal, 1);
        press(0);
        chk("top_blk", blk, 1);
        chk("top_blk_y", y_pos, 0);
        tick(1);
        chk("top_blk_end", blk, 0);
        tick(10);

        respawn = 1'b1;
        tick(1);
        respawn = 1'b0;
        chk("respawn_y", y_pos, 192);
        chk("respawn_hop", hop, 0);
        tick(10);

        up = 1'b1; rt = 1'b1;
        tick(1);
        up = 1'b0; rt = 1'b0;
        chk("prio_y", y_pos, 176);
        chk("prio_x", x_pos, 160);
        tick(10);

        for (int i = 0; i < 9; i++) begin
            press(3);
            tick(10);
        end
        chk("right_edge_x", x_pos, 304);
        press(3);
        chk("right_blk", blk, 1);
        chk("right_blk_x", x_pos, 304);
        tick(2);

        respawn = 1'b1; lf = 1'b1;
        tick(1);
        respawn = 1'b0; lf = 1'b0;
        chk("respawn_left_x", x_pos, 160);
        chk("respawn_left_y", y_pos, 192);
        chk("respawn_left_hop", hop, 0);
        tick(10);

        lf = 1'b1;
        tick(1);
        chk("hold_left_x", x_pos, 144);
        chk("hold_left_hop", hop, 1);
        tick(59);
        lf = 1'b0;
`ifndef HOP_REPEAT_EN
        chk("hold_left_single_x", x_pos, 144);
`endif
        tick(30);

        press(1);
        tick(10);
        press(1);
        chk("down_bottom_y", y_pos, 224);
        tick(10);
        press(1);
        chk("down_blk", blk, 1);
        chk("down_blk_y", y_pos, 224);
        tick(10);

        press(2);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("midcd_reset_x", x_pos, 160);
        chk("midcd_reset_y", y_pos, 192);
        chk("midcd_reset_hop", hop, 0);
        rst = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
